// File: rtl/rnd_pack.sv
// Final rounder stage: packs sign/exponent/significand into an IEEE single or
// double word, queues it with its event flags in a skid FIFO, and keeps sticky flags.
module rnd_pack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned FLAGW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic             db,
    input  logic [10:0]      e3,
    input  logic [52:0]      f3,
    input  logic             ovf_in,
    input  logic             unf_in,
    input  logic             inx_in,
    input  logic             inv_in,
    input  logic             dbz_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      fp_out,
    output logic [FLAGW-1:0] ev_flags,
    output logic [FLAGW-1:0] sticky_flags,
    input  logic             flags_clr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [FLAGW-1:0] sticky_q, sticky_d;
    logic             init_q;

    logic [63:0]      word_mem [DEPTH];
    logic [FLAGW-1:0] flag_mem [DEPTH];

    occ_e             occ;
    logic             push, pop;
    logic [10:0]      exp_field;
    logic [63:0]      pack_word;
    logic [FLAGW-1:0] pack_flags;
    logic [63:0]      head_word;
    logic [FLAGW-1:0] head_flags;

    // A cleared hidden bit means zero or denormal, whose exponent field is 0.
    always_comb begin
        exp_field = f3[52] ? e3 : '0;
        if (db) begin
            pack_word = {s, exp_field, f3[51:0]};
        end else begin
            pack_word = {32'b0, s, exp_field[7:0], f3[51:29]};
        end
        pack_flags = FLAGW'({inv_in, dbz_in, ovf_in, unf_in, inx_in});
    end

    always_comb begin
        if (cnt_q == '0) begin
            occ = OCC_EMPTY;
        end else if (cnt_q == PW'(DEPTH)) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end
    end

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = init_q & (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head_word  = word_mem[rd_q[AW-1:0]];
    assign head_flags = flag_mem[rd_q[AW-1:0]];
    assign fp_out       = out_valid ? head_word : '0;
    assign ev_flags     = out_valid ? head_flags : '0;
    assign sticky_flags = sticky_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + PW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - PW'(1);
        end
        // Clear first, then fold in the word leaving this cycle.
        sticky_d = (flags_clr ? '0 : sticky_q) | (pop ? head_flags : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= '0;
            init_q   <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            init_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                flag_mem[i] <= '0;
            end
        end else if (push) begin
            word_mem[wr_q[AW-1:0]] <= pack_word;
            flag_mem[wr_q[AW-1:0]] <= pack_flags;
        end
    end

endmodule

// File: tb/tb_rnd_pack.sv
// Scoreboard bench for rnd_pack: expected words queued at acceptance,
// compared in order against words leaving the FIFO.
module tb_rnd_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic        db;
    logic [10:0] e3;
    logic [52:0] f3;
    logic        ovf_in, unf_in, inx_in, inv_in, dbz_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic [4:0]  ev_flags;
    logic [4:0]  sticky_flags;
    logic        flags_clr;

    int checks = 0;
    int errors = 0;

    logic [68:0] exp_q [$];
    logic [68:0] got_q [$];
    logic [68:0] ref_q [$];

    rnd_pack #(.DEPTH(2), .FLAGW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .s            (s),
        .db           (db),
        .e3           (e3),
        .f3           (f3),
        .ovf_in       (ovf_in),
        .unf_in       (unf_in),
        .inx_in       (inx_in),
        .inv_in       (inv_in),
        .dbz_in       (dbz_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fp_out       (fp_out),
        .ev_flags     (ev_flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [68:0] model(input logic s_, input logic db_,
                                          input logic [10:0] e_, input logic [52:0] f_,
                                          input logic [4:0] fl);
        logic [10:0] fld;
        logic [63:0] w;
        fld = f_[52] ? e_ : 11'd0;
        if (db_) w = {s_, fld, f_[51:0]};
        else     w = {32'd0, s_, fld[7:0], f_[51:29]};
        return {w, fl};
    endfunction

    task automatic drive(input logic v, input logic s_, input logic db_,
                         input logic [10:0] e_, input logic [52:0] f_, input logic [4:0] fl);
        in_valid = v;
        s        = s_;
        db       = db_;
        e3       = e_;
        f3       = f_;
        {inv_in, dbz_in, ovf_in, unf_in, inx_in} = fl;
    endtask

    // One clock: record transfers at the negedge, then step to just after posedge.
    task automatic tick();
        logic [68:0] unk;
        unk = 'x;
        @(negedge clk);
        if (out_valid && out_ready) begin
            got_q.push_back({fp_out, ev_flags});
            if (exp_q.size() > 0) ref_q.push_back(exp_q.pop_front());
            else                  ref_q.push_back(unk);
        end
        if (in_valid && in_ready)
            exp_q.push_back(model(s, db, e3, f3, {inv_in, dbz_in, ovf_in, unf_in, inx_in}));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (fp_out !== 64'd0) begin errors++; $display("FAIL reset_fp_out got %h exp 0", fp_out); end
        checks++;
        if (sticky_flags !== 5'd0) begin errors++; $display("FAIL reset_sticky got %b exp 00000", sticky_flags); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_double();
        logic [68:0] g, r;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 11'h400, {1'b1, 52'h8000000000000}, 5'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL double_latency got %b exp 1", out_valid); end
        checks++;
        if (fp_out !== 64'hC008000000000000) begin errors++; $display("FAIL double_word got %h exp c008000000000000", fp_out); end
        checks++;
        if (ev_flags !== 5'd0) begin errors++; $display("FAIL double_flags got %b exp 00000", ev_flags); end
        tick();
        tick();
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); r = ref_q.pop_front(); checks++;
            if (g !== r) begin errors++; $display("FAIL double_sb got %h exp %h", g, r); end
        end
    endtask

    task automatic test_single();
        logic [68:0] g, r;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 11'h07F, {1'b1, 23'h400000, 29'h1ABCDEF0}, 5'd0);
        tick();
        checks++;
        if (fp_out !== 64'h000000003FC00000) begin errors++; $display("FAIL single_word got %h exp 000000003fc00000", fp_out); end
        drive(1'b1, 1'b0, 1'b0, 11'h07F, {1'b0, 23'h400000, 29'h0000FFFF}, 5'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        checks++;
        if (fp_out !== 64'h0000000000400000) begin errors++; $display("FAIL single_denorm got %h exp 0000000000400000", fp_out); end
        tick();
        tick();
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL single_count got %0d exp 2", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); r = ref_q.pop_front(); checks++;
            if (g !== r) begin errors++; $display("FAIL single_sb got %h exp %h", g, r); end
        end
    endtask

    task automatic test_backpressure();
        logic [68:0] g, r;
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 11'h3FF, {1'b1, 52'h1111111111111}, 5'b00001);
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
        drive(1'b1, 1'b1, 1'b1, 11'h123, {1'b1, 52'h2222222222222}, 5'b00010);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
        drive(1'b1, 1'b0, 1'b0, 11'h081, {1'b1, 52'h3333333333333}, 5'b00100);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_held got %b exp 0", in_ready); end
        checks++;
        if (fp_out !== 64'h3FF1111111111111) begin errors++; $display("FAIL bp_head_stable got %h exp 3ff1111111111111", fp_out); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        tick();
        tick();
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); r = ref_q.pop_front(); checks++;
            if (g !== r) begin errors++; $display("FAIL bp_sb got %h exp %h", g, r); end
        end
    endtask

    task automatic test_wrap();
        logic [68:0] g, r;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 11'h200, {1'b1, 52'hABCDE00000000}, 5'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 11'($urandom),
                  {1'($urandom_range(1)), 20'($urandom), 32'($urandom)}, 5'($urandom));
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL wrap_occupancy cycle %0d got valid %b ready %b exp 1 1", i, out_valid, in_ready);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        tick();
        tick();
        checks++;
        if (got_q.size() != 9) begin errors++; $display("FAIL wrap_count got %0d exp 9", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); r = ref_q.pop_front(); checks++;
            if (g !== r) begin errors++; $display("FAIL wrap_sb got %h exp %h", g, r); end
        end
    endtask

    task automatic test_sticky();
        logic [68:0] g, r;
        out_ready = 1'b1;
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        checks++;
        if (sticky_flags !== 5'd0) begin errors++; $display("FAIL sticky_clear got %b exp 00000", sticky_flags); end
        drive(1'b1, 1'b0, 1'b1, 11'h7FF, {1'b1, 52'd0}, 5'b00101);
        tick();
        checks++;
        if (sticky_flags !== 5'd0) begin errors++; $display("FAIL sticky_on_push got %b exp 00000", sticky_flags); end
        drive(1'b1, 1'b0, 1'b1, 11'h000, {1'b0, 52'h0000000000001}, 5'b00010);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        tick();
        checks++;
        if (sticky_flags !== 5'b00111) begin errors++; $display("FAIL sticky_accum got %b exp 00111", sticky_flags); end
        drive(1'b1, 1'b1, 1'b1, 11'h7FF, {1'b1, 52'h8000000000000}, 5'b10000);
        out_ready = 1'b0;
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        out_ready = 1'b1;
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        checks++;
        if (sticky_flags !== 5'b10000) begin errors++; $display("FAIL sticky_clr_pop got %b exp 10000", sticky_flags); end
        tick();
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); r = ref_q.pop_front(); checks++;
            if (g !== r) begin errors++; $display("FAIL sticky_sb got %h exp %h", g, r); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 11'h555, {1'b1, 52'h5555555555555}, 5'b01000);
        tick();
        drive(1'b1, 1'b1, 1'b1, 11'h2AA, {1'b1, 52'hAAAAAAAAAAAAA}, 5'b00001);
        tick();
        drive(1'b0, 1'b0, 1'b0, 11'd0, 53'd0, 5'd0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_prefull got %b exp 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", out_valid); end
        checks++;
        if (fp_out !== 64'd0) begin errors++; $display("FAIL areset_fp_out got %h exp 0", fp_out); end
        checks++;
        if (sticky_flags !== 5'd0) begin errors++; $display("FAIL areset_sticky got %b exp 00000", sticky_flags); end
        exp_q.delete();
        got_q.delete();
        ref_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", in_ready); end
        repeat (3) tick();
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL areset_stale got %0d words exp 0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_double();
        test_single();
        test_backpressure();
        test_wrap();
        test_sticky();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
